exu_mdu: RTL and testbench

Parametrised multi-cycle execute unit for the RV M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. It sits beside the single-cycle ALU in the execute stage. It uses the same valid/ready handshake toward IDU (upstream) and LSU (downstream), and carries an opaque sideband tag (rd, pc, write-enables) alongside the operation. It generalises the two-state execute handshake to an XLEN-wide iterative datapath with variable latency, back-to-back issue and flush.

---
 rtl/exu_mdu.sv | 181 ++++++++++++++++++
 tb/tb_exu_mdu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_mdu.sv
// exu_mdu: iterative multiply/divide execute unit for the RV M extension.
// One result bit per BUSY cycle (shift-add multiply, restoring divide),
// divide-by-zero and signed overflow resolved at accept without iterating.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised, holds its payload stable until that edge, and
// ready never depends combinationally on the valid it is paired with.
module exu_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_func3,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          func_q, func_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     a_q, a_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d; // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]     res_q, res_d;

  // Operand preparation for the op presented on the input
  logic            sgn1, sgn2, s1_neg, s2_neg, div_zero, div_ovf, ld_neg;
  logic [XLEN-1:0] mag1, mag2;

  // Decode signedness, take magnitudes and spot the special divide cases
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (in_func3)
      3'd0, 3'd1, 3'd4, 3'd6: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'd2:                   begin sgn1 = 1'b1; sgn2 = 1'b0; end
      default:                begin sgn1 = 1'b0; sgn2 = 1'b0; end
    endcase
    s1_neg   = sgn1 & in_src1[XLEN-1];
    s2_neg   = sgn2 & in_src2[XLEN-1];
    mag1     = s1_neg ? (~in_src1 + 1'b1) : in_src1;
    mag2     = s2_neg ? (~in_src2 + 1'b1) : in_src2;
    div_zero = in_func3[2] && (in_src2 == '0);
    div_ovf  = in_func3[2] && !in_func3[0] && (in_src1 == MIN_NEG) && (in_src2 == ONES);
    // Remainder takes the dividend's sign; product and quotient take s1^s2
    ld_neg   = (in_func3[2] && in_func3[1]) ? s1_neg : (s1_neg ^ s2_neg);
  end

  // One iteration of the datapath and the sign/select applied on exit
  logic [XLEN:0]     sum, rem_sh;
  logic [XLEN+1:0]   trial;
  logic [2*XLEN-1:0] mul_nx, div_nx, step, prod_s;
  logic [XLEN-1:0]   qr_sel, qr_s, fin;
  logic              unused_bits;

  // Shift-add multiply step, restoring divide step, final sign fix-up
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx = {sum, acc_q[XLEN-1:1]};
    rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    trial  = {1'b0, rem_sh} - {2'b00, a_q};
    // Borrow out means the divisor did not fit: keep the shifted remainder
    div_nx = trial[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                           : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step   = func_q[2] ? div_nx : mul_nx;
    prod_s = neg_q ? (~step + 1'b1) : step;
    qr_sel = func_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    qr_s   = neg_q ? (~qr_sel + 1'b1) : qr_sel;
    if (func_q[2])              fin = qr_s;
    else if (func_q[1:0] == '0) fin = prod_s[XLEN-1:0];
    else                        fin = prod_s[2*XLEN-1:XLEN];
    // After a successful subtract the remainder is below the divisor, so
    // the top trial bit and the shifted-out remainder bit are always zero
    unused_bits = trial[XLEN] ^ rem_sh[XLEN];
  end

  assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));

  logic accept, load;

  // Next-state and datapath control: iterate in BUSY, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    a_d     = a_q;
    acc_d   = acc_q;
    res_d   = res_q;
    load    = 1'b0;
    accept  = in_valid && in_ready;

    case (state_q)
      S_IDLE: load = accept;
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = fin;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          load    = accept;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      func_d = in_func3;
      tag_d  = in_tag;
      neg_d  = ld_neg;
      if (div_zero) begin
        state_d = S_DONE;
        cnt_d   = '0;
        res_d   = in_func3[1] ? in_src1 : ONES;
      end else if (div_ovf) begin
        state_d = S_DONE;
        cnt_d   = '0;
        res_d   = in_func3[1] ? '0 : in_src1;
      end else begin
        state_d = S_BUSY;
        cnt_d   = CW'(XLEN);
        acc_d   = {{XLEN{1'b0}}, (in_func3[2] ? mag1 : mag2)};
        a_d     = in_func3[2] ? mag2 : mag1;
      end
    end

    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_exu_mdu.sv
// tb_exu_mdu: directed and randomized checks of exu_mdu against an
// arithmetic reference model; results are scored in handshake order.
module tb_exu_mdu;

  localparam int XLEN  = 32;
  localparam int TAG_W = 48;
  localparam int MAXW  = 300;
  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_func3 = '0;
  logic [XLEN-1:0]  in_src1 = '0;
  logic [XLEN-1:0]  in_src2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       dbg_state;

  exu_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func3(in_func3),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0]  exp_q[$];
  logic [TAG_W-1:0] tag_exp_q[$];
  bit rand_bp = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: RV M semantics from plain 64-bit arithmetic
  function automatic logic [XLEN-1:0] ref_op(input logic [2:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    ub_s = ub;
    ovf  = (a == MIN_NEG) && (b == ONES);
    p    = '0;
    case (f)
      3'd0: begin p = sa * sb;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return ONES;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return ONES;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == MIN_NEG && b == ONES));
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_out", 64'(exp_q.size()), 1);
      else begin
        check_eq("result", out_result, exp_q.pop_front());
        check_eq("tag", out_tag, tag_exp_q.pop_front());
      end
    end
  end

  // Random downstream backpressure
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tg);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_func3 = f; in_src1 = a; in_src2 = b; in_tag = tg;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < MAXW) begin
      n++;
      @(negedge clk);
    end
    check_eq("accept_wait", 64'(n >= MAXW), 0);
    exp_q.push_back(ref_op(f, a, b));
    tag_exp_q.push_back(tg);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < MAXW);
  endtask

  function automatic logic [TAG_W-1:0] rand_tag();
    return {16'($urandom), 32'($urandom)};
  endfunction

  typedef struct {
    logic [2:0]      f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] e;
  } op_t;

  op_t dir[12];

  // ---------------- main sequence ----------------
  initial begin
    int lat, n, k;
    logic [2:0] f;
    logic [XLEN-1:0] a, b, r1;
    logic [TAG_W-1:0] tg, tg2;

    dir = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
      '{3'd5, 32'd100,        32'd7,         32'd14},
      '{3'd7, 32'd100,        32'd7,         32'd2},
      '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd7, 32'd5,          32'd0,         32'd5},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
    };

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", in_ready, 1);

    // Directed ops with out_ready high
    foreach (dir[i]) begin
      issue(dir[i].f, dir[i].a, dir[i].b, rand_tag());
      wait_valid(lat);
      check_eq($sformatf("lat_%0d", i), lat, is_special(dir[i].f, dir[i].a, dir[i].b) ? 1 : XLEN + 1);
      check_eq($sformatf("dir_res_%0d", i), out_result, dir[i].e);
    end

    // Backpressure: hold DONE, then handshake-out and accept on one edge
    @(posedge clk); #1;
    out_ready = 1'b0;
    tg = rand_tag();
    a = $urandom; b = $urandom;
    issue(3'd1, a, b, tg);
    wait_valid(lat);
    check_eq("bp_lat", lat, XLEN + 1);
    r1 = ref_op(3'd1, a, b);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_hold_res", out_result, r1);
      check_eq("bp_hold_tag", out_tag, tg);
      check_eq("bp_hold_valid", out_valid, 1);
      check_eq("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    tg2 = rand_tag();
    a = $urandom; b = $urandom_range(1, 1000);
    out_ready = 1'b1;
    in_valid = 1'b1; in_func3 = 3'd5; in_src1 = a; in_src2 = b; in_tag = tg2;
    exp_q.push_back(ref_op(3'd5, a, b));
    tag_exp_q.push_back(tg2);
    @(negedge clk);
    check_eq("bp_in_ready_high", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < MAXW) begin
      n++;
      @(negedge clk);
    end
    check_eq("bp_gap", n, XLEN);

    // Flush in the tenth BUSY cycle
    issue(3'd5, 32'hDEAD_BEEF, 32'd13, rand_tag());
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1; in_func3 = 3'd0; in_src1 = 32'd1; in_src2 = 32'd1;
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    void'(tag_exp_q.pop_back());
    @(negedge clk);
    check_eq("flush_state", dbg_state, 0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check_eq("flush_no_valid", n, 0);

    // Asynchronous reset mid-BUSY
    issue(3'd0, $urandom, $urandom, rand_tag());
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_result", out_result, 0);
    check_eq("arst_tag", out_tag, 0);
    check_eq("arst_state", dbg_state, 0);
    exp_q.delete();
    tag_exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b1;
    issue(3'd0, 32'd3, 32'd4, rand_tag());
    wait_valid(lat);
    check_eq("post_rst_lat", lat, XLEN + 1);
    check_eq("post_rst_mul", out_result, 12);

    // Randomized ops, back-to-back issue under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      k = $urandom_range(0, 15);
      if (k == 0) b = '0;
      else if (k == 1) begin a = MIN_NEG; b = ONES; end
      else if (k < 5) begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
      issue(f, a, b, rand_tag());
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
